// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store bus sequencer with pipeline stall, held load data and stall counter
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mem_type,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                exp_detect,
  input  logic                en_ex_mem,
  input  logic                en_mem_wb,
  output logic                data_req,
  output logic                data_wr,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W/8-1:0] data_wstrb,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic [31:0]         stall_cycles
);
  localparam logic [1:0] MEM_LOAD = 2'd1, MEM_STOR = 2'd2;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;
  logic armed, issue, capture;
  logic [DATA_W-1:0] rdata_q;
  always_comb begin
    issue = state == IDLE && armed && (mem_type == MEM_LOAD || mem_type == MEM_STOR) && !exp_detect;
    capture = (state == REQ && data_addr_ok && data_data_ok) || (state == WAIT && data_data_ok);
    mem_stall = issue || state == REQ || state == WAIT;
  end
  assign mem_rdata = rdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
      data_req <= 1'b0;
      data_wr <= 1'b0;
      data_addr <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
      rdata_q <= '0;
      stall_cycles <= '0;
    end else begin
      armed <= en_ex_mem || (armed && !issue);
      stall_cycles <= stall_cycles + 32'(mem_stall);
      if (capture) rdata_q <= data_rdata;
      case (state)
        IDLE: if (issue) begin
          state <= REQ;
          data_req <= 1'b1;
          data_wr <= mem_type == MEM_STOR;
          data_addr <= mem_addr;
          data_wdata <= mem_wdata;
          data_wstrb <= mem_wstrb;
        end
        REQ: if (data_addr_ok) begin
          data_req <= 1'b0;
          state <= data_data_ok ? DONE : WAIT;
        end
        WAIT: if (data_data_ok) state <= DONE;
        DONE: if (en_mem_wb) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
  localparam logic [1:0] MEM_NOOP = 2'd0, MEM_LOAD = 2'd1, MEM_STOR = 2'd2;
  logic clk = 0, rst = 1;
  logic [1:0] mem_type = MEM_NOOP;
  logic [31:0] mem_addr = 0, mem_wdata = 0, data_rdata = 0;
  logic [3:0] mem_wstrb = 0;
  logic exp_detect = 0, en_ex_mem = 0, en_mem_wb = 0, data_addr_ok = 0, data_data_ok = 0;
  logic data_req, data_wr, mem_stall;
  logic [31:0] data_addr, data_wdata, mem_rdata, stall_cycles;
  logic [3:0] data_wstrb;
  int checks = 0, errors = 0;
  logic [31:0] exp_sc = 0;
  logic [31:0] exp_q[$];

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .exp_detect(exp_detect), .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .mem_stall(mem_stall), .mem_rdata(mem_rdata), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] rd, input int aw, input int dl, input int hold,
                        input bit chain, input bit exc, input bit handoff);
    int k, reqs, stalls;
    bit done;
    logic [31:0] held, e;
    if (!chain) begin
      @(negedge clk);
      en_ex_mem = 1; en_mem_wb = 0;
    end
    @(negedge clk);
    en_ex_mem = 0; en_mem_wb = 0; exp_detect = 0;
    mem_type = t; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    if (t == MEM_LOAD) exp_q.push_back(rd);
    #1;
    checks++;
    if (mem_stall !== 1'b1 || data_req !== 1'b0) begin
      errors++; $display("FAIL issue_cycle: stall=%b req=%b, required stall=1 req=0", mem_stall, data_req);
    end
    stalls = 1; reqs = 0; k = 0; done = 0;
    while (!done && k < 64) begin
      @(negedge clk);
      if (data_req === 1'b1) begin
        reqs++;
        checks++;
        if (data_addr !== a || data_wr !== (t == MEM_STOR) || (t == MEM_STOR && (data_wdata !== wd || data_wstrb !== ws))) begin
          errors++; $display("FAIL payload: addr=%h wr=%b wdata=%h wstrb=%b, required addr=%h wr=%b wdata=%h wstrb=%b",
                             data_addr, data_wr, data_wdata, data_wstrb, a, t == MEM_STOR, wd, ws);
        end
      end
      data_addr_ok = data_req && k == aw;
      data_data_ok = k == aw + dl;
      data_rdata = data_data_ok ? rd : 32'hA5A5_0000 + k;
      exp_detect = exc && data_req;
      #1;
      if (mem_stall === 1'b1) stalls++; else done = 1;
      k++;
    end
    data_addr_ok = 0; data_data_ok = 0; exp_detect = 0;
    exp_sc += aw + dl + 2;
    checks++;
    if (stalls != aw + dl + 2) begin
      errors++; $display("FAIL stall_len: got %0d cycles, required %0d", stalls, aw + dl + 2);
    end
    checks++;
    if (reqs != aw + 1) begin
      errors++; $display("FAIL req_len: got %0d cycles, required %0d", reqs, aw + 1);
    end
    checks++;
    if (stall_cycles !== exp_sc) begin
      errors++; $display("FAIL stall_cycles: got %0d, required %0d", stall_cycles, exp_sc);
    end
    if (t == MEM_LOAD) begin
      e = exp_q.pop_front();
      checks++;
      if (mem_rdata !== e) begin
        errors++; $display("FAIL load_data: got %h, required %h", mem_rdata, e);
      end
    end
    held = mem_rdata;
    for (int i = 0; i < hold; i++) begin
      if (i > 0) @(negedge clk);
      data_data_ok = i == 1 && hold > 2;
      data_rdata = ~rd;
      en_mem_wb = i == hold - 1;
      en_ex_mem = handoff && i == hold - 1;
      #1;
      checks++;
      if (mem_stall !== 1'b0 || data_req !== 1'b0 || mem_rdata !== held) begin
        errors++; $display("FAIL done_hold[%0d]: stall=%b req=%b rdata=%h, required stall=0 req=0 rdata=%h",
                           i, mem_stall, data_req, mem_rdata, held);
      end
    end
    data_data_ok = 0;
    if (!handoff) begin
      @(negedge clk);
      en_mem_wb = 0; en_ex_mem = 0;
      #1;
      checks++;
      if (mem_stall !== 1'b0 || data_req !== 1'b0 || mem_rdata !== held) begin
        errors++; $display("FAIL idle_after: stall=%b req=%b rdata=%h, required 0 0 %h", mem_stall, data_req, mem_rdata, held);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (data_req !== 0 || data_wr !== 0 || data_addr !== 0 || data_wdata !== 0 || data_wstrb !== 0 ||
        mem_stall !== 0 || mem_rdata !== 0 || stall_cycles !== 0) begin
      errors++; $display("FAIL reset: req=%b wr=%b addr=%h wdata=%h wstrb=%b stall=%b rdata=%h sc=%0d, required all 0",
                         data_req, data_wr, data_addr, data_wdata, data_wstrb, mem_stall, mem_rdata, stall_cycles);
    end
    rst = 0;
    exp_sc = 0;
  endtask

  task automatic test_load();
    run_op(MEM_LOAD, 32'h1000_0004, 0, 0, 32'hDEAD_BEEF, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic test_store_backpressure();
    run_op(MEM_STOR, 32'h8000_0010, 32'h1234_5678, 4'b0011, 32'h0, 4, 1, 1, 0, 0, 0);
  endtask

  task automatic test_done_hold();
    run_op(MEM_LOAD, 32'h2000_0100, 0, 0, 32'hCAFE_F00D, 1, 0, 7, 0, 0, 0);
  endtask

  task automatic test_exception();
    @(negedge clk);
    en_ex_mem = 1; mem_type = MEM_NOOP;
    @(negedge clk);
    en_ex_mem = 0;
    #1;
    checks++;
    if (mem_stall !== 0 || data_req !== 0) begin
      errors++; $display("FAIL noop_issue: stall=%b req=%b, required 0 0", mem_stall, data_req);
    end
    @(negedge clk);
    en_ex_mem = 1;
    @(negedge clk);
    en_ex_mem = 0; mem_type = MEM_LOAD; mem_addr = 32'h3000_0000; exp_detect = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (mem_stall !== 0 || data_req !== 0) begin
        errors++; $display("FAIL exc_suppress[%0d]: stall=%b req=%b, required 0 0", i, mem_stall, data_req);
      end
    end
    run_op(MEM_LOAD, 32'h3000_0008, 0, 0, 32'h0BAD_CAFE, 1, 2, 1, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    run_op(MEM_LOAD, 32'h4000_0000, 0, 0, 32'h1111_2222, 0, 1, 1, 0, 0, 1);
    run_op(MEM_LOAD, 32'h4000_0004, 0, 0, 32'h3333_4444, 0, 1, 2, 1, 0, 1);
    run_op(MEM_LOAD, 32'h4000_0008, 0, 0, 32'h5555_6666, 2, 0, 1, 1, 0, 0);
  endtask

  task automatic test_random();
    bit ho = 0, nho;
    for (int n = 0; n < 8; n++) begin
      nho = n < 7 && $urandom_range(0, 1) == 1;
      run_op((n % 2 == 0) ? MEM_LOAD : MEM_STOR, $urandom, $urandom, 4'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(1, 4), ho, n == 3, nho);
      ho = nho;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    en_ex_mem = 1;
    @(negedge clk);
    en_ex_mem = 0; mem_type = MEM_LOAD; mem_addr = 32'h5000_0000;
    @(negedge clk);
    data_addr_ok = 1;
    #1;
    checks++;
    if (data_req !== 1) begin
      errors++; $display("FAIL rst_mid_req: req=%b, required 1", data_req);
    end
    @(negedge clk);
    data_addr_ok = 0;
    #1;
    checks++;
    if (mem_stall !== 1 || data_req !== 0) begin
      errors++; $display("FAIL rst_mid_wait: stall=%b req=%b, required 1 0", mem_stall, data_req);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (data_req !== 0 || mem_stall !== 0 || stall_cycles !== 0 || mem_rdata !== 0) begin
      errors++; $display("FAIL rst_mid: req=%b stall=%b sc=%0d rdata=%h, required 0 0 0 0", data_req, mem_stall, stall_cycles, mem_rdata);
    end
    exp_sc = 0;
    run_op(MEM_LOAD, 32'h5000_0004, 0, 0, 32'h7777_8888, 1, 1, 1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_backpressure();
    test_done_hold();
    test_exception();
    test_back_to_back();
    test_random();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
